// File: rtl/pkg_display.sv
// ---------------------------------------------------------------------------
// pkg_display
// Shared definitions for the 7-segment display path (driver and reader).
//   SEG_0..SEG_9, SEG_APAGADO : segment patterns, bit6 = a ... bit0 = g,
//                               active-high
//   COD_APAGADO               : nibble used for a blank digit
//   COD_INVALIDO              : nibble reported for an unrecognised pattern
//   estado_t                  : reader FSM states (collect / deliver)
// ---------------------------------------------------------------------------
package pkg_display;

   localparam logic [6:0] SEG_0       = 7'b1111110;
   localparam logic [6:0] SEG_1       = 7'b0110000;
   localparam logic [6:0] SEG_2       = 7'b1101101;
   localparam logic [6:0] SEG_3       = 7'b1111001;
   localparam logic [6:0] SEG_4       = 7'b0110011;
   localparam logic [6:0] SEG_5       = 7'b1011011;
   localparam logic [6:0] SEG_6       = 7'b1011111;
   localparam logic [6:0] SEG_7       = 7'b1110000;
   localparam logic [6:0] SEG_8       = 7'b1111111;
   localparam logic [6:0] SEG_9       = 7'b1110011;
   localparam logic [6:0] SEG_APAGADO = 7'b0000000;

   localparam logic [3:0] COD_APAGADO  = 4'hF;
   localparam logic [3:0] COD_INVALIDO = 4'hE;

   typedef enum logic {
      COLETA  = 1'b0,
      ENTREGA = 1'b1
   } estado_t;

endpackage

// File: rtl/decod_padrao_7seg.sv
// ---------------------------------------------------------------------------
// decod_padrao_7seg
// Combinational translation of one 7-segment pattern back into a BCD nibble.
//   segmentos : segment pattern, bit6 = a ... bit0 = g
//   valido    : 1 when the pattern is a digit 0-9 or blank
//   nibble    : decoded value (blank -> 4'hF, unrecognised -> 4'hE)
// ---------------------------------------------------------------------------
module decod_padrao_7seg
   import pkg_display::*;
(
   input  logic [6:0] segmentos,
   output logic       valido,
   output logic [3:0] nibble
);

   always_comb begin
      valido = 1'b1;
      nibble = COD_INVALIDO;
      case (segmentos)
         SEG_0:       nibble = 4'd0;
         SEG_1:       nibble = 4'd1;
         SEG_2:       nibble = 4'd2;
         SEG_3:       nibble = 4'd3;
         SEG_4:       nibble = 4'd4;
         SEG_5:       nibble = 4'd5;
         SEG_6:       nibble = 4'd6;
         SEG_7:       nibble = 4'd7;
         SEG_8:       nibble = 4'd8;
         SEG_9:       nibble = 4'd9;
         SEG_APAGADO: nibble = COD_APAGADO;
         default: begin
            valido = 1'b0;
            nibble = COD_INVALIDO;
         end
      endcase
   end

endmodule

// File: rtl/decodificador_7segmentos.sv
// ---------------------------------------------------------------------------
// decodificador_7segmentos
// Reads back a multiplexed 7-segment bus and rebuilds the displayed code.
// Each digit must be seen ESTAVEL_CICLOS times in a row with the same value
// before it is committed; once every digit is committed the whole word is
// offered to the consumer with a valid/ready handshake.
//   clock, reset_n : clock (rising edge) and asynchronous active-low reset
//   amostra        : sample strobe for segmentos_in / digito_sel
//   segmentos_in   : segment pattern, bit6 = a ... bit0 = g
//   digito_sel     : one-hot digit select, bit i = digit i
//   codigo_out     : assembled code, digit i in [4i+3:4i]
//   codigo_valido  : code word valid
//   codigo_pronto  : consumer ready
//   erro_padrao    : one-cycle pulse, unrecognised segment pattern
//   erro_selecao   : one-cycle pulse, digito_sel not one-hot on a sample
// ---------------------------------------------------------------------------
module decodificador_7segmentos
   import pkg_display::*;
#(
   parameter int NUM_DIGITOS    = 4,
   parameter int ESTAVEL_CICLOS = 3
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     amostra,
   input  logic [6:0]               segmentos_in,
   input  logic [NUM_DIGITOS-1:0]   digito_sel,
   output logic [4*NUM_DIGITOS-1:0] codigo_out,
   output logic                     codigo_valido,
   input  logic                     codigo_pronto,
   output logic                     erro_padrao,
   output logic                     erro_selecao
);

   localparam int               CNT_W   = $clog2(ESTAVEL_CICLOS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ESTAVEL_CICLOS);
   localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

   estado_t                  estado;
   logic [NUM_DIGITOS-1:0]   mascara;
   logic [4*NUM_DIGITOS-1:0] buffer;
   logic [CNT_W-1:0]         contador [NUM_DIGITOS];
   logic [3:0]               ultimo   [NUM_DIGITOS];

   logic                     padrao_valido;
   logic [3:0]               padrao_nibble;
   logic                     sel_unico;
   logic [NUM_DIGITOS-1:0]   alvo;

   decod_padrao_7seg u_decod (
      .segmentos (segmentos_in),
      .valido    (padrao_valido),
      .nibble    (padrao_nibble)
   );

   // A select is usable only with exactly one bit set; no priority encoding,
   // so a multi-hot select can never be mistaken for one of its bits.
   // Digits already committed drop out of the target set so they stay frozen.
   assign sel_unico = ($countones(digito_sel) == 1);
   assign alvo      = digito_sel & ~mascara;

   function automatic logic [CNT_W-1:0] incrementa(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? CNT_MAX : c + CNT_UM;
   endfunction

   // Collect/deliver FSM. In COLETA every strobed sample updates the
   // stability counter of its digit; when the mask fills up, the following
   // cycle publishes the buffer. In ENTREGA the word is held until the
   // consumer accepts it, then all per-digit state is cleared for a fresh
   // frame while codigo_out keeps showing the last delivered word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado        <= COLETA;
         mascara       <= '0;
         buffer        <= '0;
         codigo_out    <= '0;
         codigo_valido <= 1'b0;
         erro_padrao   <= 1'b0;
         erro_selecao  <= 1'b0;
         for (int i = 0; i < NUM_DIGITOS; i++) begin
            contador[i] <= '0;
            ultimo[i]   <= COD_APAGADO;
         end
      end else begin
         erro_padrao  <= 1'b0;
         erro_selecao <= 1'b0;
         case (estado)
            COLETA: begin
               if (&mascara) begin
                  codigo_out    <= buffer;
                  codigo_valido <= 1'b1;
                  estado        <= ENTREGA;
               end else if (amostra) begin
                  if (!sel_unico) begin
                     erro_selecao <= 1'b1;
                  end else if (|alvo) begin
                     if (!padrao_valido) begin
                        erro_padrao <= 1'b1;
                     end
                     for (int i = 0; i < NUM_DIGITOS; i++) begin
                        if (alvo[i]) begin
                           if (!padrao_valido) begin
                              contador[i] <= '0;
                           end else if (padrao_nibble == ultimo[i]) begin
                              contador[i] <= incrementa(contador[i]);
                              if (incrementa(contador[i]) == CNT_MAX) begin
                                 buffer[4*i +: 4] <= padrao_nibble;
                                 mascara[i]       <= 1'b1;
                              end
                           end else begin
                              // A new value restarts the run; with a
                              // threshold of one this first sample commits.
                              ultimo[i]   <= padrao_nibble;
                              contador[i] <= CNT_UM;
                              if (CNT_UM == CNT_MAX) begin
                                 buffer[4*i +: 4] <= padrao_nibble;
                                 mascara[i]       <= 1'b1;
                              end
                           end
                        end
                     end
                  end
               end
            end
            ENTREGA: begin
               if (codigo_pronto) begin
                  codigo_valido <= 1'b0;
                  mascara       <= '0;
                  estado        <= COLETA;
                  for (int i = 0; i < NUM_DIGITOS; i++) begin
                     contador[i] <= '0;
                     ultimo[i]   <= COD_APAGADO;
                  end
               end
            end
            default: estado <= COLETA;
         endcase
      end
   end

endmodule

// File: tb/tb_decodificador_7segmentos.sv
// ---------------------------------------------------------------------------
// tb_decodificador_7segmentos
// Directed bench for the 7-segment read-back decoder (4 digits, threshold 3).
// Each scenario task drives its own stimulus and checks the outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_decodificador_7segmentos;

   localparam logic [6:0] P0 = 7'b1111110;
   localparam logic [6:0] P1 = 7'b0110000;
   localparam logic [6:0] P2 = 7'b1101101;
   localparam logic [6:0] P3 = 7'b1111001;
   localparam logic [6:0] P4 = 7'b0110011;
   localparam logic [6:0] P5 = 7'b1011011;
   localparam logic [6:0] P6 = 7'b1011111;
   localparam logic [6:0] P7 = 7'b1110000;
   localparam logic [6:0] P8 = 7'b1111111;
   localparam logic [6:0] P9 = 7'b1110011;
   localparam logic [6:0] PB = 7'b0000000;
   localparam logic [6:0] PX = 7'b1000001;

   logic        clock;
   logic        reset_n;
   logic        amostra;
   logic [6:0]  segmentos_in;
   logic [3:0]  digito_sel;
   logic [15:0] codigo_out;
   logic        codigo_valido;
   logic        codigo_pronto;
   logic        erro_padrao;
   logic        erro_selecao;

   int checks;
   int failures;

   decodificador_7segmentos #(
      .NUM_DIGITOS    (4),
      .ESTAVEL_CICLOS (3)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .amostra       (amostra),
      .segmentos_in  (segmentos_in),
      .digito_sel    (digito_sel),
      .codigo_out    (codigo_out),
      .codigo_valido (codigo_valido),
      .codigo_pronto (codigo_pronto),
      .erro_padrao   (erro_padrao),
      .erro_selecao  (erro_selecao)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One strobed sample; returns 1 time unit after the capturing edge.
   task automatic do_sample(input logic [3:0] sel, input logic [6:0] seg);
      amostra      = 1'b1;
      digito_sel   = sel;
      segmentos_in = seg;
      @(posedge clock);
      #1;
      amostra      = 1'b0;
      digito_sel   = 4'b0000;
      segmentos_in = PB;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic commit_digit(input logic [3:0] sel, input logic [6:0] seg);
      for (int k = 0; k < 3; k++) do_sample(sel, seg);
   endtask

   task automatic handshake();
      codigo_pronto = 1'b1;
      @(posedge clock);
      #1;
      codigo_pronto = 1'b0;
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      amostra       = 1'b0;
      digito_sel    = 4'b0000;
      segmentos_in  = PB;
      codigo_pronto = 1'b0;
      idle(2);
      checks++;
      if (codigo_out !== 16'h0000 || codigo_valido !== 1'b0 ||
          erro_padrao !== 1'b0 || erro_selecao !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got out=%h v=%b ep=%b es=%b exp 0000/0/0/0",
                  codigo_out, codigo_valido, erro_padrao, erro_selecao);
      end
      reset_n = 1'b1;
      idle(1);
   endtask

   task automatic test_basic_frame();
      commit_digit(4'b1000, P1);
      commit_digit(4'b0100, P9);
      commit_digit(4'b0010, P8);
      commit_digit(4'b0001, P4);
      checks++;
      if (codigo_valido !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_latency_early got v=%b exp 0", codigo_valido);
      end
      idle(1);
      checks++;
      if (codigo_valido !== 1'b1) begin
         failures++;
         $display("[TB] FAIL basic_valid got v=%b exp 1", codigo_valido);
      end
      checks++;
      if (codigo_out !== 16'h1984) begin
         failures++;
         $display("[TB] FAIL basic_code got %h exp 1984", codigo_out);
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 10; k++) begin
         amostra      = 1'($urandom);
         digito_sel   = 4'($urandom);
         segmentos_in = 7'($urandom);
         @(posedge clock);
         #1;
         checks++;
         if (codigo_out !== 16'h1984 || codigo_valido !== 1'b1 ||
             erro_padrao !== 1'b0 || erro_selecao !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_hold cycle=%0d got out=%h v=%b ep=%b es=%b exp 1984/1/0/0",
                     k, codigo_out, codigo_valido, erro_padrao, erro_selecao);
         end
      end
      amostra      = 1'b0;
      digito_sel   = 4'b0000;
      segmentos_in = PB;
      handshake();
      checks++;
      if (codigo_valido !== 1'b0 || codigo_out !== 16'h1984) begin
         failures++;
         $display("[TB] FAIL handshake_release got v=%b out=%h exp 0/1984",
                  codigo_valido, codigo_out);
      end
   endtask

   task automatic test_glitch_filter();
      commit_digit(4'b1000, P2);
      commit_digit(4'b0100, P3);
      commit_digit(4'b0010, P7);
      do_sample(4'b0001, P5);
      do_sample(4'b0001, P5);
      do_sample(4'b0001, P6);
      do_sample(4'b0001, P6);
      idle(2);
      checks++;
      if (codigo_valido !== 1'b0) begin
         failures++;
         $display("[TB] FAIL glitch_early_commit got v=%b exp 0", codigo_valido);
      end
      do_sample(4'b0001, P6);
      idle(1);
      checks++;
      if (codigo_valido !== 1'b1 || codigo_out !== 16'h2376) begin
         failures++;
         $display("[TB] FAIL glitch_code got v=%b out=%h exp 1/2376",
                  codigo_valido, codigo_out);
      end
      handshake();
   endtask

   task automatic test_invalid_pattern();
      commit_digit(4'b1000, P0);
      commit_digit(4'b0010, P5);
      commit_digit(4'b0001, P9);
      do_sample(4'b0100, P7);
      do_sample(4'b0100, P7);
      do_sample(4'b0100, PX);
      checks++;
      if (erro_padrao !== 1'b1) begin
         failures++;
         $display("[TB] FAIL invalid_pulse got ep=%b exp 1", erro_padrao);
      end
      idle(1);
      checks++;
      if (erro_padrao !== 1'b0) begin
         failures++;
         $display("[TB] FAIL invalid_pulse_width got ep=%b exp 0", erro_padrao);
      end
      do_sample(4'b0100, P7);
      do_sample(4'b0100, P7);
      idle(2);
      checks++;
      if (codigo_valido !== 1'b0) begin
         failures++;
         $display("[TB] FAIL invalid_counter_cleared got v=%b exp 0", codigo_valido);
      end
      do_sample(4'b0100, P7);
      idle(1);
      checks++;
      if (codigo_valido !== 1'b1 || codigo_out !== 16'h0759) begin
         failures++;
         $display("[TB] FAIL invalid_code got v=%b out=%h exp 1/0759",
                  codigo_valido, codigo_out);
      end
      handshake();
   endtask

   task automatic test_bad_select();
      commit_digit(4'b1000, P8);
      do_sample(4'b0100, P4);
      do_sample(4'b0100, P4);
      do_sample(4'b0011, P4);
      checks++;
      if (erro_selecao !== 1'b1) begin
         failures++;
         $display("[TB] FAIL select_multi got es=%b exp 1", erro_selecao);
      end
      do_sample(4'b0000, P4);
      checks++;
      if (erro_selecao !== 1'b1) begin
         failures++;
         $display("[TB] FAIL select_zero got es=%b exp 1", erro_selecao);
      end
      idle(1);
      checks++;
      if (erro_selecao !== 1'b0) begin
         failures++;
         $display("[TB] FAIL select_pulse_width got es=%b exp 0", erro_selecao);
      end
      commit_digit(4'b1000, P9);
      do_sample(4'b0100, P4);
      commit_digit(4'b0010, P1);
      commit_digit(4'b0001, P2);
      idle(1);
      checks++;
      if (codigo_valido !== 1'b1 || codigo_out !== 16'h8412) begin
         failures++;
         $display("[TB] FAIL select_code got v=%b out=%h exp 1/8412",
                  codigo_valido, codigo_out);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      commit_digit(4'b1000, P3);
      commit_digit(4'b0100, P3);
      reset_n = 1'b0;
      #2;
      checks++;
      if (codigo_out !== 16'h0000 || codigo_valido !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mid_frame got out=%h v=%b exp 0000/0",
                  codigo_out, codigo_valido);
      end
      reset_n = 1'b1;
      idle(1);
      commit_digit(4'b0001, P6);
      commit_digit(4'b0010, P5);
      idle(2);
      checks++;
      if (codigo_valido !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_mask_cleared got v=%b exp 0", codigo_valido);
      end
      commit_digit(4'b1000, P7);
      commit_digit(4'b0100, P0);
      idle(1);
      checks++;
      if (codigo_valido !== 1'b1 || codigo_out !== 16'h7056) begin
         failures++;
         $display("[TB] FAIL reset_fresh_code got v=%b out=%h exp 1/7056",
                  codigo_valido, codigo_out);
      end
      reset_n = 1'b0;
      #2;
      checks++;
      if (codigo_out !== 16'h0000 || codigo_valido !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_in_delivery got out=%h v=%b exp 0000/0",
                  codigo_out, codigo_valido);
      end
      reset_n = 1'b1;
      idle(1);
   endtask

   task automatic test_blank();
      commit_digit(4'b1000, PB);
      commit_digit(4'b0100, P1);
      commit_digit(4'b0010, P2);
      commit_digit(4'b0001, P3);
      idle(1);
      checks++;
      if (codigo_valido !== 1'b1 || codigo_out !== 16'hF123) begin
         failures++;
         $display("[TB] FAIL blank_code got v=%b out=%h exp 1/F123",
                  codigo_valido, codigo_out);
      end
      checks++;
      if (erro_padrao !== 1'b0) begin
         failures++;
         $display("[TB] FAIL blank_no_error got ep=%b exp 0", erro_padrao);
      end
      handshake();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_glitch_filter();
      test_invalid_pattern();
      test_bad_select();
      test_reset_mid();
      test_blank();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
